// File: rtl/vrased_log_pkg.sv
// Shared constants and types for the violation log path (logger, log RAM,
// drain). Holds the entry geometry, RAM capacity, the drain FSM state
// encoding and a helper that pads an entry out to whole bytes.
package vrased_log_pkg;

    localparam int ENTRY_W         = 37;
    localparam int ADDR_W          = 16;
    localparam logic [15:0] MAX_ENTRIES = 16'd1024;
    localparam int BYTES_PER_ENTRY = 5;
    localparam int SER_W           = 8 * BYTES_PER_ENTRY;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        SEND  = 3'd3,
        CLEAR = 3'd4
    } drain_state_e;

    // Zero-extend a log entry to the byte-aligned serializer width.
    function automatic logic [SER_W-1:0] pad_entry(input logic [ENTRY_W-1:0] entry);
        pad_entry = {{(SER_W - ENTRY_W){1'b0}}, entry};
    endfunction

endpackage

// File: rtl/log_byte_ser.sv
// Byte serializer for one padded log entry.
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   load           - load load_data and start presenting byte 0
//   load_data      - padded entry, byte 0 = bits 7:0
//   tx_ready       - consumer accepts the current byte
//   tx_data        - current byte (register output, stable while stalled)
//   tx_valid       - tx_data is valid
//   done           - high in the cycle the last byte is accepted
module log_byte_ser (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             load,
    input  logic [vrased_log_pkg::SER_W-1:0] load_data,
    input  logic                             tx_ready,
    output logic [7:0]                       tx_data,
    output logic                             tx_valid,
    output logic                             done
);
    import vrased_log_pkg::*;

    localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_ENTRY - 1);

    logic [SER_W-1:0] shift_r;
    logic [2:0]       idx_r;
    logic             valid_r;

    // Load, then shift one byte out per accepted handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_r <= '0;
            idx_r   <= 3'd0;
            valid_r <= 1'b0;
        end else if (load) begin
            shift_r <= load_data;
            idx_r   <= 3'd0;
            valid_r <= 1'b1;
        end else if (valid_r && tx_ready) begin
            shift_r <= {8'h00, shift_r[SER_W-1:8]};
            if (idx_r == LAST_IDX) begin
                idx_r   <= 3'd0;
                valid_r <= 1'b0;
            end else begin
                idx_r   <= idx_r + 3'd1;
            end
        end
    end

    // The byte on the wire is the low byte of the shift register, so it
    // never depends combinationally on tx_ready.
    assign tx_data  = shift_r[7:0];
    assign tx_valid = valid_r;
    // Internal completion strobe: lets the FSM move on in the same cycle as
    // the final handshake so an entry costs exactly five SEND cycles.
    assign done     = valid_r && tx_ready && (idx_r == LAST_IDX);

endmodule

// File: rtl/log_drain.sv
// Log readout stage: counts logger writes, and on drain_req reads every
// logged entry through the RAM read port, streams each as 5 bytes, then
// pulses clr_ram to empty the log.
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   log_we                  - logger write strobe (sequential addresses from 0)
//   drain_req               - single-cycle drain request (ignored unless idle)
//   ram_re, ram_rd_addr     - RAM read port request
//   ram_rd_data             - RAM read data, valid one cycle after ram_re
//   tx_data/tx_valid/tx_ready - byte stream toward the debug UART
//   clr_ram                 - one-cycle log clear pulse
//   busy                    - FSM is not idle
//   overflow                - sticky: a write arrived while the log was full
module log_drain #(
    parameter int                ENTRY_W     = vrased_log_pkg::ENTRY_W,
    parameter int                ADDR_W      = vrased_log_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] MAX_ENTRIES = vrased_log_pkg::MAX_ENTRIES
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               log_we,
    input  logic               drain_req,
    output logic               ram_re,
    output logic [ADDR_W-1:0]  ram_rd_addr,
    input  logic [ENTRY_W-1:0] ram_rd_data,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               clr_ram,
    output logic               busy,
    output logic               overflow
);
    import vrased_log_pkg::*;

    localparam logic [ADDR_W:0] MAX_EXT = {1'b0, MAX_ENTRIES};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    drain_state_e      state_r;
    logic [ADDR_W:0]   entry_cnt_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic              overflow_r;

    logic              cnt_inc_s;
    logic              ovf_hit_s;
    logic [ADDR_W:0]   cnt_next_s;
    logic [ADDR_W-1:0] rd_ptr_inc_s;
    logic [ADDR_W:0]   rd_ptr_inc_ext_s;
    logic              clr_s;
    logic              ser_load_s;
    logic              ser_done_s;

    // Write accounting, next read pointer and the clear decision.
    always_comb begin
        cnt_inc_s        = 1'b0;
        ovf_hit_s        = 1'b0;
        cnt_next_s       = entry_cnt_r;
        rd_ptr_inc_s     = rd_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        rd_ptr_inc_ext_s = {1'b0, rd_ptr_r} + CNT_ONE;
        if (log_we) begin
            if (entry_cnt_r < MAX_EXT) begin
                cnt_inc_s  = 1'b1;
                cnt_next_s = entry_cnt_r + CNT_ONE;
            end else begin
                ovf_hit_s  = 1'b1;
            end
        end else begin
            cnt_inc_s = 1'b0;
        end
        // A write landing in CLEAR cancels the clear so the late entry is
        // drained first. A write dropped because the log is full cannot be
        // read back, so it does not hold off the clear.
        clr_s      = (state_r == CLEAR) && !cnt_inc_s;
        ser_load_s = (state_r == WAIT);
    end

    // Drain FSM together with the entry counter, read pointer and overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            entry_cnt_r <= '0;
            rd_ptr_r    <= '0;
            rd_addr_r   <= '0;
            overflow_r  <= 1'b0;
        end else begin
            if (clr_s) begin
                entry_cnt_r <= '0;
                overflow_r  <= 1'b0;
            end else begin
                entry_cnt_r <= cnt_next_s;
                overflow_r  <= overflow_r | ovf_hit_s;
            end

            case (state_r)
                IDLE: begin
                    if (drain_req && (entry_cnt_r != '0)) begin
                        state_r   <= READ;
                        rd_addr_r <= rd_ptr_r;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                READ: begin
                    state_r <= WAIT;
                end
                WAIT: begin
                    state_r <= SEND;
                end
                SEND: begin
                    if (ser_done_s) begin
                        rd_ptr_r <= rd_ptr_inc_s;
                        // Compare against the count including this cycle's
                        // write so a same-cycle entry is not skipped.
                        if (rd_ptr_inc_ext_s < cnt_next_s) begin
                            state_r   <= READ;
                            rd_addr_r <= rd_ptr_inc_s;
                        end else begin
                            state_r   <= CLEAR;
                        end
                    end else begin
                        state_r <= SEND;
                    end
                end
                CLEAR: begin
                    if (clr_s) begin
                        rd_ptr_r <= '0;
                        state_r  <= IDLE;
                    end else begin
                        state_r   <= READ;
                        rd_addr_r <= rd_ptr_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    log_byte_ser u_ser (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (ser_load_s),
        .load_data (pad_entry(ram_rd_data)),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .done      (ser_done_s)
    );

    assign ram_re      = (state_r == READ);
    assign ram_rd_addr = rd_addr_r;
    assign clr_ram     = clr_s;
    assign busy        = (state_r != IDLE);
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_log_drain.sv
// Directed bench for log_drain: a logger/RAM model feeds the DUT and every
// expected value is hand-computed or derived from the written data.
module tb_log_drain;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        log_we;
    logic        drain_req;
    logic        ram_re;
    logic [15:0] ram_rd_addr;
    logic [36:0] ram_rd_data = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        clr_ram;
    logic        busy;
    logic        overflow;

    logic [36:0] wdata;
    logic [36:0] mem [0:1023];
    int          wp;

    int checks = 0;
    int errors = 0;

    // Results of the last drain run
    logic [7:0] got [$];
    int  clr_cnt, re_cnt, busy_cnt, first_re, first_valid, stall_used;
    logic [7:0] stall_val;
    bit  stall_ok, finished;

    always #5 clk = ~clk;

    log_drain dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .log_we      (log_we),
        .drain_req   (drain_req),
        .ram_re      (ram_re),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .clr_ram     (clr_ram),
        .busy        (busy),
        .overflow    (overflow)
    );

    // Logger + RAM model: sequential writes from 0, emptied by clr_ram.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp <= 0;
        end else if (clr_ram) begin
            wp <= 0;
        end else if (log_we && wp < 1024) begin
            mem[wp] <= wdata;
            wp      <= wp + 1;
        end
    end

    // RAM read port with one cycle of latency.
    always @(posedge clk) begin
        if (ram_re) ram_rd_data <= mem[ram_rd_addr[9:0]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [36:0] d);
        @(negedge clk);
        log_we = 1'b1;
        wdata  = d;
        @(negedge clk);
        log_we = 1'b0;
    endtask

    function automatic logic [36:0] patt(input int i);
        logic [31:0] v;
        logic [31:0] iv;
        iv = i;
        v  = iv * 32'h9E37_79B9;
        return {iv[4:0], v};
    endfunction

    // Issue drain_req and observe until busy falls or the budget expires.
    task automatic do_drain(input int budget, input int stall_byte, input int stall_len,
                            input int late_k, input logic [36:0] late_data);
        bit seen_busy;
        got.delete();
        clr_cnt = 0; re_cnt = 0; busy_cnt = 0; first_re = -1; first_valid = -1;
        stall_used = 0; stall_ok = 1'b1; finished = 1'b0; seen_busy = 1'b0;
        @(negedge clk);
        drain_req = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            drain_req = 1'b0;
            log_we    = (k == late_k);
            wdata     = late_data;
            tx_ready  = 1'b1;
            if (tx_valid && got.size() == stall_byte && stall_used < stall_len) begin
                tx_ready = 1'b0;
                if (stall_used == 0) stall_val = tx_data;
                stall_used++;
            end
            #1;
            if (ram_re) begin
                re_cnt++;
                if (first_re < 0) first_re = k;
            end
            if (tx_valid && first_valid < 0) first_valid = k;
            if (tx_valid && !tx_ready && tx_data !== stall_val) stall_ok = 1'b0;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            if (clr_ram) clr_cnt++;
            if (busy) begin
                busy_cnt++;
                seen_busy = 1'b1;
            end else if (seen_busy) begin
                finished = 1'b1;
                break;
            end
        end
        log_we = 1'b0;
    endtask

    initial begin
        logic [7:0]  exp2 [10];
        logic [7:0]  exp3 [15];
        logic [39:0] ext;
        int          bad;
        int          nacc;
        bit          hit;

        exp2 = '{8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        exp3 = '{8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h12, 8'hF0, 8'hDE, 8'hBC, 8'h1A};

        reset_n = 1'b0; log_we = 1'b0; drain_req = 1'b0; tx_ready = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ram_re", ram_re, 0);
        chk("rst_addr", ram_rd_addr, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_clr", clr_ram, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Two entries, tx_ready held high
        wr(37'h1_2345_6789);
        wr(37'h0_0000_00FF);
        do_drain(60, 99, 0, 0, '0);
        chk("two_done", finished, 1);
        chk("two_nbytes", got.size(), 10);
        for (int i = 0; i < 10 && i < got.size(); i++) chk($sformatf("two_byte%0d", i), got[i], exp2[i]);
        chk("two_first_re", first_re, 1);
        chk("two_first_valid", first_valid, 3);
        chk("two_re_cnt", re_cnt, 2);
        chk("two_clr_cnt", clr_cnt, 1);
        chk("two_busy_cycles", busy_cnt, 15);

        // Backpressure on byte 2 for 3 cycles
        wr(37'h1_2345_6789);
        wr(37'h0_0000_00FF);
        do_drain(60, 2, 3, 0, '0);
        chk("bp_done", finished, 1);
        chk("bp_nbytes", got.size(), 10);
        for (int i = 0; i < 10 && i < got.size(); i++) chk($sformatf("bp_byte%0d", i), got[i], exp2[i]);
        chk("bp_stall_used", stall_used, 3);
        chk("bp_held_val", stall_val, 8'h45);
        chk("bp_held_stable", stall_ok, 1);
        chk("bp_clr_cnt", clr_cnt, 1);
        chk("bp_busy_cycles", busy_cnt, 18);

        // Empty log: nothing happens
        do_drain(10, 99, 0, 0, '0);
        chk("empty_re", re_cnt, 0);
        chk("empty_clr", clr_cnt, 0);
        chk("empty_busy", busy_cnt, 0);
        chk("empty_valid", first_valid, -1);

        // Late write coinciding with CLEAR (cycle t+15)
        wr(37'h1_2345_6789);
        wr(37'h0_0000_00FF);
        do_drain(80, 99, 0, 15, 37'h1A_BCDE_F012);
        chk("late_done", finished, 1);
        chk("late_nbytes", got.size(), 15);
        for (int i = 0; i < 15 && i < got.size(); i++) chk($sformatf("late_byte%0d", i), got[i], exp3[i]);
        chk("late_re_cnt", re_cnt, 3);
        chk("late_clr_cnt", clr_cnt, 1);
        chk("late_busy_cycles", busy_cnt, 23);
        do_drain(10, 99, 0, 0, '0);
        chk("late_after_empty_re", re_cnt, 0);
        chk("late_after_empty_busy", busy_cnt, 0);

        // Overflow: 1025 writes into a 1024-entry log
        for (int i = 0; i < 1024; i++) wr(patt(i));
        #1;
        chk("ovf_before", overflow, 0);
        wr(patt(1024));
        #1;
        chk("ovf_set", overflow, 1);
        do_drain(7 * 1024 + 40, 99, 0, 0, '0);
        chk("ovf_done", finished, 1);
        chk("ovf_nbytes", got.size(), 5 * 1024);
        bad = 0;
        for (int e = 0; e < 1024; e++) begin
            ext = {3'b000, patt(e)};
            for (int b = 0; b < 5; b++) begin
                if (e * 5 + b >= got.size() || got[e * 5 + b] !== ext[8 * b +: 8]) bad++;
            end
        end
        chk("ovf_byte_mismatches", bad, 0);
        chk("ovf_clr_cnt", clr_cnt, 1);
        chk("ovf_cleared", overflow, 0);

        // Reset while byte 3 is on the wire
        wr(37'h1A_BCDE_F012);
        @(negedge clk);
        drain_req = 1'b1;
        nacc = 0;
        hit  = 1'b0;
        for (int k = 1; k <= 20 && !hit; k++) begin
            @(negedge clk);
            drain_req = 1'b0;
            tx_ready  = 1'b1;
            #1;
            if (tx_valid && nacc == 3) begin
                hit = 1'b1;
                chk("rstmid_byte3", tx_data, 8'hBC);
                reset_n = 1'b0;
                #1;
                chk("rstmid_ram_re", ram_re, 0);
                chk("rstmid_addr", ram_rd_addr, 0);
                chk("rstmid_tx_data", tx_data, 0);
                chk("rstmid_tx_valid", tx_valid, 0);
                chk("rstmid_clr", clr_ram, 0);
                chk("rstmid_busy", busy, 0);
                chk("rstmid_ovf", overflow, 0);
            end else if (tx_valid) begin
                nacc++;
            end
        end
        chk("rstmid_reached", hit, 1);
        @(negedge clk);
        reset_n = 1'b1;
        do_drain(10, 99, 0, 0, '0);
        chk("rstmid_after_re", re_cnt, 0);
        chk("rstmid_after_busy", busy_cnt, 0);
        chk("rstmid_after_clr", clr_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
